ram_arbiter: RTL and testbench

- Two-port round-robin arbiter and sequencer for the shared single-port 16x8 RAM.
- The RAM has control inputs wr_en, rd_en and Addr, and a bidirectional Data bus.
- Two requesters issue single-word read or write transactions over a req/ack handshake.
- The arbiter serialises them, drives the RAM control and Data bus, captures read data and returns it to the winning requester.

---
 rtl/ram_arbiter_if.sv | 37 +++
 rtl/ram_arbiter.sv | 115 +++++++++++
 tb/tb_ram_arbiter.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// Requester and RAM-control signals of the two-port RAM arbiter.
// The bidirectional Data bus is a plain port on the arbiter itself.
interface ram_arbiter_if #(
   parameter int AW = 4,
   parameter int DW = 8
);
   logic          req0;
   logic          we0;
   logic [AW-1:0] addr0;
   logic [DW-1:0] wdata0;
   logic          ack0;
   logic [DW-1:0] rdata0;
   logic          req1;
   logic          we1;
   logic [AW-1:0] addr1;
   logic [DW-1:0] wdata1;
   logic          ack1;
   logic [DW-1:0] rdata1;
   logic          wr_en;
   logic          rd_en;
   logic [AW-1:0] Addr;
   logic          busy;

   modport master (
      output req0, we0, addr0, wdata0,
      output req1, we1, addr1, wdata1,
      input  ack0, rdata0, ack1, rdata1,
      input  wr_en, rd_en, Addr, busy
   );

   modport slave (
      input  req0, we0, addr0, wdata0,
      input  req1, we1, addr1, wdata1,
      output ack0, rdata0, ack1, rdata1,
      output wr_en, rd_en, Addr, busy
   );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter and sequencer for a shared single-port RAM:
// one-cycle writes, two-cycle reads, registered ack pulses.
module ram_arbiter #(
   parameter int AW = 4,
   parameter int DW = 8
) (
   input  logic          Clk,
   input  logic          Rst_n,
   ram_arbiter_if.slave  bus,
   inout  wire  [DW-1:0] Data
);
   typedef enum logic [1:0] {
      IDLE,
      WR,
      RD,
      RD_CAP
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic          r_gnt;
   logic          r_last;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wdata;
   logic          r_ack0;
   logic          r_ack1;
   logic [DW-1:0] r_rdata0;
   logic [DW-1:0] r_rdata1;
   logic          w_any;
   logic          w_pick;
   logic          w_pick_we;
   logic          w_done;
   logic          w_drive;
   logic          w_wr_en;
   logic          w_rd_en;
   logic          w_busy;

   // w_pick = 1 grants port 1; on contention the port not served last wins
   assign w_any     = bus.req0 | bus.req1;
   assign w_pick    = bus.req1 & (~bus.req0 | ~r_last);
   assign w_pick_we = w_pick ? bus.we1 : bus.we0;
   assign w_done    = (r_state == WR) | (r_state == RD_CAP);

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (w_any) w_next = w_pick_we ? WR : RD;
         WR:      w_next = IDLE;
         RD:      w_next = RD_CAP;
         RD_CAP:  w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      w_wr_en = 1'b0;
      w_rd_en = 1'b0;
      w_drive = 1'b0;
      w_busy  = 1'b1;
      unique case (r_state)
         IDLE:    w_busy  = 1'b0;
         WR: begin
            w_wr_en = 1'b1;
            w_drive = 1'b1;
         end
         RD:      w_rd_en = 1'b1;
         RD_CAP:  w_rd_en = 1'b1;
         default: w_busy  = 1'b0;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_gnt    <= 1'b0;
         r_last   <= 1'b1;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_ack0   <= 1'b0;
         r_ack1   <= 1'b0;
         r_rdata0 <= '0;
         r_rdata1 <= '0;
      end else begin
         r_ack0 <= w_done & ~r_gnt;
         r_ack1 <= w_done & r_gnt;
         if (r_state == IDLE && w_any) begin
            r_gnt   <= w_pick;
            r_last  <= w_pick;
            r_addr  <= w_pick ? bus.addr1 : bus.addr0;
            r_wdata <= w_pick ? bus.wdata1 : bus.wdata0;
         end
         if (r_state == RD_CAP) begin
            if (r_gnt) r_rdata1 <= Data;
            else       r_rdata0 <= Data;
         end
      end
   end

   assign bus.wr_en  = w_wr_en;
   assign bus.rd_en  = w_rd_en;
   assign bus.busy   = w_busy;
   assign bus.Addr   = r_addr;
   assign bus.ack0   = r_ack0;
   assign bus.ack1   = r_ack1;
   assign bus.rdata0 = r_rdata0;
   assign bus.rdata1 = r_rdata1;
   assign Data       = w_drive ? r_wdata : {DW{1'bz}};
endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: vector table, corner sequences
// and randomized rounds against a transaction-level model.
module tb_ram_arbiter;
   logic       Clk;
   logic       Rst_n;
   wire  [7:0] Data;
   logic [7:0] ram [16];

   int checks = 0;
   int errors = 0;
   int viol   = 0;

   // transaction-level reference state
   logic [7:0] m_mem [16];
   int         m_last;
   logic [7:0] m_rd0;
   logic [7:0] m_rd1;

   ram_arbiter_if #(.AW(4), .DW(8)) bus ();

   ram_arbiter #(.AW(4), .DW(8)) dut (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .bus   (bus),
      .Data  (Data)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // behavioural RAM device
   assign Data = (bus.rd_en && !bus.wr_en) ? ram[bus.Addr] : 8'bz;
   always @(posedge Clk) if (bus.wr_en) ram[bus.Addr] <= Data;

   always @(negedge Clk) begin
      if (Rst_n) begin
         if (bus.wr_en && bus.rd_en) viol++;
         if (bus.busy !== (bus.wr_en | bus.rd_en)) viol++;
         if (bus.rd_en && Data !== ram[bus.Addr]) viol++;
      end
   end

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      m_last = 1;
      m_rd0  = 8'h00;
      m_rd1  = 8'h00;
   endtask

   task automatic model_serve(input int p, input bit w,
                              input logic [3:0] a, input logic [7:0] d);
      if (w) m_mem[a] = d;
      else if (p == 0) m_rd0 = m_mem[a];
      else m_rd1 = m_mem[a];
      m_last = p;
   endtask

   task automatic model_round(
      input bit r0, input bit w0, input logic [3:0] a0, input logic [7:0] d0,
      input bit r1, input bit w1, input logic [3:0] a1, input logic [7:0] d1,
      output int first);
      if (r0 && r1) first = (m_last == 0) ? 1 : 0;
      else first = r0 ? 0 : 1;
      if (first == 0) begin
         model_serve(0, w0, a0, d0);
         if (r1) model_serve(1, w1, a1, d1);
      end else begin
         model_serve(1, w1, a1, d1);
         if (r0) model_serve(0, w0, a0, d0);
      end
   endtask

   task automatic do_reset();
      Rst_n = 1'b0;
      @(posedge Clk);
      #1;
      Rst_n = 1'b1;
      model_reset();
   endtask

   task automatic do_round(
      input bit r0, input bit w0, input logic [3:0] a0, input logic [7:0] d0,
      input bit r1, input bit w1, input logic [3:0] a1, input logic [7:0] d1,
      output int first);
      bit p0;
      bit p1;
      p0 = r0;
      p1 = r1;
      first = -1;
      bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
      bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
      for (int c = 0; c < 16 && (p0 || p1); c++) begin
         @(posedge Clk);
         #1;
         if (bus.ack0) begin
            if (!p0) check("spurious_ack0", int'(bus.ack0), 0);
            if (first < 0) first = 0;
            p0 = 1'b0;
            bus.req0 = 1'b0;
         end
         if (bus.ack1) begin
            if (!p1) check("spurious_ack1", int'(bus.ack1), 0);
            if (first < 0) first = 1;
            p1 = 1'b0;
            bus.req1 = 1'b0;
         end
      end
      if (p0 || p1) check("round_timeout", int'(p0 || p1), 0);
   endtask

   typedef struct {
      bit         rst;
      bit         r0;
      bit         w0;
      logic [3:0] a0;
      logic [7:0] d0;
      bit         r1;
      bit         w1;
      logic [3:0] a1;
      logic [7:0] d1;
      int         first;
      logic [7:0] e0;
      logic [7:0] e1;
   } vec_t;

   vec_t tbl [8];

   initial begin
      int first;
      int mfirst;
      int nack;
      int aport [4];
      int acyc [4];
      logic [7:0] adat [4];

      tbl[0] = '{0, 1,0,4'd3,8'h00, 0,0,4'd0,8'h00, 0, 8'hA5, 8'h00};
      tbl[1] = '{1, 1,1,4'd1,8'h11, 1,1,4'd2,8'h22, 0, 8'h00, 8'h00};
      tbl[2] = '{0, 1,0,4'd1,8'h00, 0,0,4'd0,8'h00, 0, 8'h11, 8'h00};
      tbl[3] = '{0, 0,0,4'd0,8'h00, 1,0,4'd2,8'h00, 1, 8'h11, 8'h22};
      tbl[4] = '{0, 1,0,4'd2,8'h00, 1,0,4'd1,8'h00, 0, 8'h22, 8'h11};
      tbl[5] = '{0, 1,1,4'd5,8'h55, 1,1,4'd5,8'h66, 0, 8'h22, 8'h11};
      tbl[6] = '{0, 1,0,4'd5,8'h00, 0,0,4'd0,8'h00, 0, 8'h66, 8'h11};
      tbl[7] = '{0, 1,0,4'd3,8'h00, 1,0,4'd5,8'h00, 1, 8'hA5, 8'h66};

      Rst_n = 1'b0;
      bus.req0 = 0; bus.we0 = 0; bus.addr0 = 0; bus.wdata0 = 0;
      bus.req1 = 0; bus.we1 = 0; bus.addr1 = 0; bus.wdata1 = 0;
      model_reset();
      repeat (2) @(posedge Clk);
      #1;
      check("rst_wr_en", int'(bus.wr_en), 0);
      check("rst_rd_en", int'(bus.rd_en), 0);
      check("rst_addr", int'(bus.Addr), 0);
      check("rst_acks", int'({bus.ack0, bus.ack1}), 0);
      check("rst_rdata", int'({bus.rdata0, bus.rdata1}), 0);
      check("rst_busy", int'(bus.busy), 0);
      Rst_n = 1'b1;

      // write latency; inputs scrambled after the grant
      bus.req0 = 1; bus.we0 = 1; bus.addr0 = 4'd3; bus.wdata0 = 8'hA5;
      @(posedge Clk); #1;
      check("wr_en_n", int'(bus.wr_en), 1);
      check("wr_addr_n", int'(bus.Addr), 3);
      check("wr_data_n", int'(Data), 8'hA5);
      check("wr_ack_n", int'(bus.ack0), 0);
      bus.req0 = 0; bus.addr0 = 4'hF; bus.wdata0 = 8'h00;
      @(posedge Clk); #1;
      check("wr_en_n1", int'(bus.wr_en), 0);
      check("wr_ack_n1", int'(bus.ack0), 1);
      @(posedge Clk); #1;
      check("wr_ack_n2", int'(bus.ack0), 0);
      m_mem[3] = 8'hA5;
      m_last = 0;

      // read latency
      bus.req0 = 1; bus.we0 = 0; bus.addr0 = 4'd3;
      @(posedge Clk); #1;
      check("rd_en_n", int'(bus.rd_en), 1);
      check("rd_ack_n", int'(bus.ack0), 0);
      @(posedge Clk); #1;
      check("rd_en_n1", int'(bus.rd_en), 1);
      check("rd_ack_n1", int'(bus.ack0), 0);
      @(posedge Clk); #1;
      check("rd_ack_n2", int'(bus.ack0), 1);
      check("rd_data_n2", int'(bus.rdata0), 8'hA5);
      check("rd_en_n2", int'(bus.rd_en), 0);
      bus.req0 = 0;
      m_rd0 = 8'hA5;

      foreach (tbl[i]) begin
         if (tbl[i].rst) do_reset();
         model_round(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0,
                     tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1, mfirst);
         do_round(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0,
                  tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1, first);
         check($sformatf("vec%0d_first", i), first, tbl[i].first);
         check($sformatf("vec%0d_rdata0", i), int'(bus.rdata0), int'(tbl[i].e0));
         check($sformatf("vec%0d_rdata1", i), int'(bus.rdata1), int'(tbl[i].e1));
      end

      // both reads held continuously: alternate grants every 3 clocks
      do_reset();
      bus.req0 = 1; bus.we0 = 0; bus.addr0 = 4'd1;
      bus.req1 = 1; bus.we1 = 0; bus.addr1 = 4'd2;
      nack = 0;
      for (int c = 0; c < 30 && nack < 4; c++) begin
         @(posedge Clk); #1;
         if (bus.ack0 || bus.ack1) begin
            aport[nack] = bus.ack1 ? 1 : 0;
            acyc[nack] = c;
            adat[nack] = bus.ack1 ? bus.rdata1 : bus.rdata0;
            nack++;
         end
      end
      bus.req0 = 0;
      bus.req1 = 0;
      check("alt_ack_count", nack, 4);
      for (int k = 0; k < nack; k++) begin
         check($sformatf("alt_port%0d", k), aport[k], k % 2);
         check($sformatf("alt_data%0d", k), int'(adat[k]),
               int'((k % 2) ? m_mem[2] : m_mem[1]));
         if (k > 0) check($sformatf("alt_gap%0d", k), acyc[k] - acyc[k-1], 3);
      end
      m_last = 1;
      m_rd0 = m_mem[1];
      m_rd1 = m_mem[2];
      @(posedge Clk); #1;

      // fill via port 1, read back via port 0
      for (int a = 0; a < 16; a++) begin
         model_round(0, 0, 4'd0, 8'h00, 1, 1, 4'(a), 8'(a) ^ 8'h5A, mfirst);
         do_round(0, 0, 4'd0, 8'h00, 1, 1, 4'(a), 8'(a) ^ 8'h5A, first);
      end
      for (int a = 0; a < 16; a++) begin
         model_round(1, 0, 4'(a), 8'h00, 0, 0, 4'd0, 8'h00, mfirst);
         do_round(1, 0, 4'(a), 8'h00, 0, 0, 4'd0, 8'h00, first);
         check($sformatf("fill_rd%0d", a), int'(bus.rdata0), int'(8'(a) ^ 8'h5A));
      end

      // asynchronous reset while in RD
      bus.req0 = 1; bus.we0 = 0; bus.addr0 = 4'd1;
      @(posedge Clk); #1;
      check("rstrd_in_rd", int'(bus.rd_en), 1);
      #2;
      Rst_n = 1'b0;
      #1;
      check("rstrd_rd_en", int'(bus.rd_en), 0);
      check("rstrd_busy", int'(bus.busy), 0);
      check("rstrd_ack", int'(bus.ack0), 0);
      bus.req0 = 0;
      @(posedge Clk); #1;
      check("rstrd_ack_hold", int'(bus.ack0), 0);
      Rst_n = 1'b1;
      model_reset();
      @(posedge Clk); #1;
      check("rstrd_ack_after", int'(bus.ack0), 0);
      check("rstrd_rdata0", int'(bus.rdata0), 0);
      model_round(1, 1, 4'd7, 8'h77, 1, 1, 4'd8, 8'h88, mfirst);
      do_round(1, 1, 4'd7, 8'h77, 1, 1, 4'd8, 8'h88, first);
      check("rstrd_first", first, 0);

      // randomized rounds against the model
      for (int n = 0; n < 150; n++) begin
         bit r0, w0, r1, w1;
         logic [3:0] a0, a1;
         logic [7:0] d0, d1;
         r0 = 1'($urandom_range(0, 1));
         r1 = 1'($urandom_range(0, 1));
         if (!r0 && !r1) r0 = 1'b1;
         w0 = 1'($urandom_range(0, 1));
         w1 = 1'($urandom_range(0, 1));
         a0 = 4'($urandom);
         a1 = 4'($urandom);
         d0 = 8'($urandom);
         d1 = 8'($urandom);
         model_round(r0, w0, a0, d0, r1, w1, a1, d1, mfirst);
         do_round(r0, w0, a0, d0, r1, w1, a1, d1, first);
         check($sformatf("rnd%0d_first", n), first, mfirst);
         check($sformatf("rnd%0d_rdata0", n), int'(bus.rdata0), int'(m_rd0));
         check($sformatf("rnd%0d_rdata1", n), int'(bus.rdata1), int'(m_rd1));
      end

      @(posedge Clk); #1;
      check("invariants", viol, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
